fetch_unit: RTL

- Multi-cycle instruction fetch unit. It is the producer side of the instruction interface feeding decode_unit.
- Issues word requests to instruction memory, latches the returned word, and presents it with its PC to decode via a valid/ready handshake.
- Accepts PC redirects (jump/branch/trap targets) at any time and squashes in-flight fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding,
// instruction width and default reset/NOP values.
package fetch_pkg;

  localparam int unsigned INSTR_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: one outstanding memory request, registered
// valid/ready presentation to decode, redirect squashing and misaligned-target faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_err,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        instr_pc,
  output logic               fetch_fault,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic               fetch_fault_q, fetch_fault_d;
  logic               pending_misalign_q, pending_misalign_d;
  logic               redirect_misaligned;
  logic               present_fault;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    instr_valid_d      = instr_valid_q;
    instruction_d      = instruction_q;
    instr_pc_d         = instr_pc_q;
    fetch_fault_d      = fetch_fault_q;
    pending_misalign_d = pending_misalign_q;
    redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    present_fault      = 1'b0;

    if (redirect_valid) begin
      pc_d               = redirect_pc;
      pending_misalign_d = redirect_misaligned;
      case (state_q)
        REQ: begin
          // An accepted stale request still owes a response, so it must drain first.
          if (imem_req_ready) begin
            state_d = DRAIN;
          end else begin
            present_fault = redirect_misaligned;
            state_d       = REQ;
          end
        end
        WAIT, DRAIN: begin
          if (imem_rsp_valid) begin
            present_fault = redirect_misaligned;
            state_d       = REQ;
          end else begin
            state_d = DRAIN;
          end
        end
        HOLD: begin
          instr_valid_d = 1'b0;
          instruction_d = NOP_INSTR;
          fetch_fault_d = 1'b0;
          present_fault = redirect_misaligned;
          state_d       = REQ;
        end
        default: begin
          present_fault = redirect_misaligned;
          state_d       = REQ;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instruction_d = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
            instr_pc_d    = pc_q;
            fetch_fault_d = imem_rsp_err;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = HOLD;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            present_fault = pending_misalign_q;
            state_d       = REQ;
          end
        end
        HOLD: begin
          // Masking is a no-op after a normal fetch and realigns after a fault.
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            instruction_d = NOP_INSTR;
            fetch_fault_d = 1'b0;
            pc_d          = {pc_q[31:2], 2'b00};
            state_d       = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (present_fault) begin
      state_d            = HOLD;
      instr_valid_d      = 1'b1;
      fetch_fault_d      = 1'b1;
      instruction_d      = NOP_INSTR;
      instr_pc_d         = pc_d;
      pending_misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      pc_q               <= RESET_PC;
      instr_valid_q      <= 1'b0;
      instruction_q      <= NOP_INSTR;
      instr_pc_q         <= '0;
      fetch_fault_q      <= 1'b0;
      pending_misalign_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      instr_valid_q      <= instr_valid_d;
      instruction_q      <= instruction_d;
      instr_pc_q         <= instr_pc_d;
      fetch_fault_q      <= fetch_fault_d;
      pending_misalign_q <= pending_misalign_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instruction    = instruction_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_fault    = fetch_fault_q;

endmodule
